uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate in bit/s; BPS_CNT = CLK_FREQ / BAUD_RATE (integer division) clock cycles per bit.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tx_data_valid  input  1  request to send tx_data.
REQ-006 tx_data  input  8  byte to transmit, LSB first.
REQ-007 tx_ready  output  1  high when the block can accept a byte.
REQ-008 tx_done  output  1  one-cycle pulse at end of stop bit.
REQ-009 txd  output  1  UART serial line, registered, idle high.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY (macro-dependent), STOP.
REQ-011 Handshake: a byte SHALL be accepted on a rising edge where tx_data_valid=1 and tx_ready=1; tx_data is latched into an internal shift register on that edge.
REQ-012 On the accepting edge: state goes to START, txd goes 0, tx_ready goes 0, bit timer clears.
REQ-013 Bit timer: 16-bit counter counting 0..BPS_CNT-1; each line bit SHALL hold exactly BPS_CNT cycles.
REQ-014 START -> DATA after BPS_CNT cycles; DATA drives data bits 0..7 in order, bit counter 0..7, each BPS_CNT cycles.
REQ-015 After bit 7: -> PARITY if compiled in, else -> STOP; STOP drives txd=1 for BPS_CNT cycles.
REQ-016 At the end of STOP: state -> IDLE, tx_ready -> 1, tx_done high for exactly that one cycle.
REQ-017 Frame length SHALL be 10*BPS_CNT cycles (11*BPS_CNT with parity) from accepting edge to tx_ready re-assertion.
REQ-018 tx_data_valid while tx_ready=0 SHALL be ignored (no queueing); tx_data changes mid-frame SHALL not affect the frame.
REQ-019 Back-to-back: valid held high in the cycle tx_ready returns SHALL be accepted that edge; start bit follows the stop bit with no idle gap.
REQ-020 In IDLE, txd SHALL be 1 and tx_done 0.

Reset
REQ-021 On rst_n=0 (any time, including mid-frame): state IDLE, txd=1, tx_ready=1, tx_done=0, bit timer, bit counter and shift register 0.
REQ-022 A frame interrupted by reset SHALL be abandoned, not resumed; first accept after release starts a fresh frame.

Configuration
REQ-023 Macro UART_TX_PARITY_EN: when defined, a PARITY state SHALL insert one even-parity bit (XOR of the 8 data bits) between bit 7 and stop, BPS_CNT cycles long.
REQ-024 When UART_TX_PARITY_EN is undefined, no parity state or logic SHALL exist; frame is 8N1.

Verification (CLK_FREQ=50000000, BAUD_RATE=115200, BPS_CNT=434)
REQ-025 Reset: hold rst_n=0 5 cycles -> txd=1, tx_ready=1, tx_done=0; release, idle 100 cycles -> outputs unchanged.
REQ-026 Send 0x55, no parity -> txd sampled at bit centres = 0,1,0,1,0,1,0,1,0,1; tx_done pulse 4340 cycles after accept; tx_ready=0 throughout.
REQ-027 Parity build, send 0x01 -> parity bit 1; send 0x55 -> parity bit 0; frame 4774 cycles.
REQ-028 Hold tx_data_valid=1 with 0xA3 then 0x3C queued at tx_ready -> two contiguous frames, second start bit immediately after first stop bit, exactly two tx_done pulses.
REQ-029 Pulse tx_data_valid with 0xFF at cycle 1000 of an active frame -> ignored; only original byte transmitted.
REQ-030 Assert rst_n=0 during DATA bit 3 -> txd=1 same cycle asynchronously, tx_ready=1; after release send 0x0F -> correct full frame.

Source files
------------

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- serial transmitter, one start bit, 8 data bits LSB first,
// optional even parity bit, one stop bit.
//
// Optional feature macro: UART_TX_PARITY_EN
//   undefined : 8N1 frame, 10 bit-times long (no parity state or logic)
//   defined   : 8E1 frame, 11 bit-times long (even parity = XOR of data)
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line bit rate in bit/s
//   BPS_CNT    CLK_FREQ / BAUD_RATE, clock cycles per line bit (must fit
//              in the 16-bit bit timer)
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   tx_data_valid  in   request to send tx_data
//   tx_data[7:0]   in   byte to send, latched on the accepting edge
//   tx_ready       out  high while a byte can be accepted
//   tx_done        out  one-cycle pulse at the end of the stop bit
//   txd            out  registered serial line, idle high
//   dbg_state[2:0] out  current FSM state (encoding of state_t)
//
// Handshake: a byte is taken on a rising edge where tx_data_valid and
// tx_ready are both high. tx_ready is low for the whole frame and any
// tx_data_valid seen while it is low is dropped. tx_data is only sampled
// on the accepting edge, so it may change freely during a frame.
// ---------------------------------------------------------------------------
module uart_tx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_data_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       txd,
   output logic [2:0] dbg_state
);

   localparam int          BPS_CNT  = CLK_FREQ / BAUD_RATE;
   localparam logic [15:0] BPS_LAST = 16'(BPS_CNT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd4
   } state_t;
`endif

   state_t      r_state;
   logic [15:0] r_bps_cnt;   // cycles spent in the current line bit
   logic [2:0]  r_bit_cnt;   // index of the data bit being driven
   logic [7:0]  r_shift;     // remaining data bits, next one in bit 0
   logic        r_txd;
   logic        r_ready;
   logic        r_done;
`ifdef UART_TX_PARITY_EN
   logic        r_parity;    // even parity of the accepted byte
`endif

   logic        w_bit_end;   // last cycle of the current line bit
   logic        w_accept;

   assign w_bit_end = (r_bps_cnt == BPS_LAST);
   assign w_accept  = tx_data_valid && r_ready;

   // -------------------------------------------------------------------------
   // Single FSM: every output is a register updated here, so txd never
   // glitches and the line level changes exactly on bit boundaries.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_bps_cnt <= 16'd0;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'd0;
         r_txd     <= 1'b1;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_txd   <= 1'b1;
               r_ready <= 1'b1;
               if (w_accept) begin
                  // Start bit goes onto the line on the accepting edge.
                  r_state   <= S_START;
                  r_shift   <= tx_data;
                  r_txd     <= 1'b0;
                  r_ready   <= 1'b0;
                  r_bps_cnt <= 16'd0;
                  r_bit_cnt <= 3'd0;
`ifdef UART_TX_PARITY_EN
                  r_parity  <= ^tx_data;
`endif
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_bps_cnt <= 16'd0;
                  r_bit_cnt <= 3'd0;
                  r_txd     <= r_shift[0];
                  r_shift   <= {1'b0, r_shift[7:1]};
               end else begin
                  r_bps_cnt <= r_bps_cnt + 16'd1;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_bps_cnt <= 16'd0;
                  if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_txd   <= r_parity;
`else
                     r_state <= S_STOP;
                     r_txd   <= 1'b1;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     r_txd     <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_bps_cnt <= r_bps_cnt + 16'd1;
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state   <= S_STOP;
                  r_bps_cnt <= 16'd0;
                  r_txd     <= 1'b1;
               end else begin
                  r_bps_cnt <= r_bps_cnt + 16'd1;
               end
            end
`endif

            S_STOP: begin
               if (w_bit_end) begin
                  // tx_ready rises here; a byte already waiting on
                  // tx_data_valid is taken on the very next edge.
                  r_state   <= S_IDLE;
                  r_bps_cnt <= 16'd0;
                  r_bit_cnt <= 3'd0;
                  r_txd     <= 1'b1;
                  r_ready   <= 1'b1;
                  r_done    <= 1'b1;
               end else begin
                  r_bps_cnt <= r_bps_cnt + 16'd1;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_bps_cnt <= 16'd0;
               r_bit_cnt <= 3'd0;
               r_txd     <= 1'b1;
               r_ready   <= 1'b1;
            end
         endcase
      end
   end

   assign txd       = r_txd;
   assign tx_ready  = r_ready;
   assign tx_done   = r_done;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx (CLK_FREQ 50 MHz, 115200 Bd,
// 434 cycles per bit). A frame-level model predicts txd/tx_ready/tx_done
// every cycle from the accept instant and the frame bit list; directed
// tests add literal expectations for line bits, frame length and pulses.
// ---------------------------------------------------------------------------
module tb_uart_tx;

   localparam int B = 434;
`ifdef UART_TX_PARITY_EN
   localparam int NF = 11;
   localparam int FRAME_EXP = 4774;
`else
   localparam int NF = 10;
   localparam int FRAME_EXP = 4340;
`endif

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       tx_data_valid = 1'b0;
   logic [7:0] tx_data = 8'd0;
   logic       tx_ready;
   logic       tx_done;
   logic       txd;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   uart_tx #(
      .CLK_FREQ (50000000),
      .BAUD_RATE(115200)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_data_valid(tx_data_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .tx_done      (tx_done),
      .txd          (txd),
      .dbg_state    (dbg_state)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- frame-level model ----------------
   function automatic logic [10:0] frame_bits(input logic [7:0] d);
      logic [10:0] f;
      f = 11'h7FF;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
      f[9] = ^d;
`endif
      return f;
   endfunction

   logic [10:0] m_bits   = 11'h7FF;
   bit          m_active = 1'b0;
   int          m_pos    = 0;
   logic        m_txd    = 1'b1;
   logic        m_ready  = 1'b1;
   logic        m_done   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_pos    = 0;
         m_txd    = 1'b1;
         m_ready  = 1'b1;
         m_done   = 1'b0;
      end else begin
         if (m_ready && tx_data_valid) begin
            m_bits   = frame_bits(tx_data);
            m_active = 1'b1;
            m_pos    = 0;
         end else if (m_active) begin
            m_pos++;
         end
         m_done = 1'b0;
         if (m_active && m_pos < NF * B) begin
            m_txd   = m_bits[m_pos / B];
            m_ready = 1'b0;
         end else begin
            if (m_active) m_done = 1'b1;
            m_active = 1'b0;
            m_txd    = 1'b1;
            m_ready  = 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("txd_model", {31'd0, txd}, {31'd0, m_txd});
         check("ready_model", {31'd0, tx_ready}, {31'd0, m_ready});
         check("done_model", {31'd0, tx_done}, {31'd0, m_done});
      end
      if (tx_done === 1'b1) n_done++;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready_level(input logic lvl, input string name);
      int n;
      n = 0;
      while (tx_ready !== lvl && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) check({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   // Present a byte, return the accepting edge (cycle count).
   task automatic send_byte(input logic [7:0] d, output int a);
      wait_ready_level(1'b1, "ready_high");
      tx_data_valid = 1'b1;
      tx_data       = d;
      @(negedge clk);
      wait_ready_level(1'b0, "accept");
      a = cyc;
      tx_data_valid = 1'b0;
   endtask

   // txd at the centre of each line bit of the frame accepted at edge a.
   task automatic sample_frame(input int a, output logic [10:0] got);
      int target;
      got = 11'd0;
      for (int i = 0; i < NF; i++) begin
         target = a + i * B + B / 2;
         while (cyc < target) @(negedge clk);
         got[i] = txd;
      end
   endtask

   // ---------------- scoreboard of expected frames ----------------
   logic [10:0] exp_q[$];
   logic [10:0] got;
   int          a, a1, a2, n, d0;

   initial begin
      // reset: 5 cycles low
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_done", {31'd0, tx_done}, 32'd0);
      check("rst_state", {29'd0, dbg_state}, 32'd0);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check("idle_txd", {31'd0, txd}, 32'd1);
      check("idle_ready", {31'd0, tx_ready}, 32'd1);
      check("idle_done_count", n_done, 32'd0);

      // expected line bits (bit i = centre of line bit i)
`ifdef UART_TX_PARITY_EN
      exp_q.push_back(11'h4AA);   // 0x55, parity 0
      exp_q.push_back(11'h602);   // 0x01, parity 1
      exp_q.push_back(11'h52C);   // 0x96
      exp_q.push_back(11'h41E);   // 0x0F
`else
      exp_q.push_back(11'h2AA);   // 0x55
      exp_q.push_back(11'h202);   // 0x01
      exp_q.push_back(11'h32C);   // 0x96
      exp_q.push_back(11'h21E);   // 0x0F
`endif

      // 0x55: bit pattern and done latency
      send_byte(8'h55, a);
      check("start_on_accept", {31'd0, txd}, 32'd0);
      sample_frame(a, got);
      check("frame_55", {21'd0, got}, {21'd0, exp_q.pop_front()});
      n = 0;
      while (tx_done !== 1'b1 && n < 2 * B) begin
         @(negedge clk);
         n++;
      end
      check("done_latency", cyc - a, FRAME_EXP);
      check("ready_after_done", {31'd0, tx_ready}, 32'd1);

      // 0x01: parity 1 when compiled in
      send_byte(8'h01, a);
      sample_frame(a, got);
      check("frame_01", {21'd0, got}, {21'd0, exp_q.pop_front()});
      wait_ready_level(1'b1, "end_01");

      // back-to-back with valid held high
      repeat (3) @(negedge clk);
      d0 = n_done;
      tx_data_valid = 1'b1;
      tx_data       = 8'hA3;
      @(negedge clk);
      wait_ready_level(1'b0, "b2b_accept1");
      a1 = cyc;
      tx_data = 8'h3C;
      wait_ready_level(1'b1, "b2b_ready");
      wait_ready_level(1'b0, "b2b_accept2");
      a2 = cyc;
      tx_data_valid = 1'b0;
      check("b2b_spacing", a2 - a1, FRAME_EXP + 1);
      check("b2b_start2", {31'd0, txd}, 32'd0);
      repeat (FRAME_EXP + 5) @(negedge clk);
      check("b2b_done_pulses", n_done - d0, 32'd2);

      // 0x96 with a 0xFF pulse at cycle 1000 of the frame
      send_byte(8'h96, a);
      fork
         begin
            while (cyc < a + 1000) @(negedge clk);
            tx_data_valid = 1'b1;
            tx_data       = 8'hFF;
            @(negedge clk);
            tx_data_valid = 1'b0;
         end
         sample_frame(a, got);
      join
      check("frame_96_ignore_ff", {21'd0, got}, {21'd0, exp_q.pop_front()});
      wait_ready_level(1'b1, "end_96");

      // reset during data bit 3, then a fresh 0x0F frame
      send_byte(8'hC6, a);
      while (cyc < a + 4 * B + 100) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_txd", {31'd0, txd}, 32'd1);
      check("async_rst_ready", {31'd0, tx_ready}, 32'd1);
      check("async_rst_done", {31'd0, tx_done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_idle_txd", {31'd0, txd}, 32'd1);
      d0 = n_done;
      send_byte(8'h0F, a);
      sample_frame(a, got);
      check("frame_0f", {21'd0, got}, {21'd0, exp_q.pop_front()});
      wait_ready_level(1'b1, "end_0f");
      check("frame_0f_length", cyc - a, FRAME_EXP);
      repeat (5) @(negedge clk);
      check("frame_0f_done", n_done - d0, 32'd1);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
